// File: rtl/data_stack_pkg.sv
// data_stack_pkg: shared fault codes, read-source tags and default widths for the data/stack memory.
package data_stack_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;
  localparam int RAM_DEPTH_DEF = 300;
  localparam int STK_DEPTH_DEF = 300;
  typedef enum logic [1:0] {
    FAULT_NONE  = 2'b00,
    FAULT_OVF   = 2'b01,
    FAULT_UNF   = 2'b10,
    FAULT_RANGE = 2'b11
  } fault_t;
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_STK
  } rd_src_t;
endpackage

// File: rtl/data_stack_memory_if.sv
// data_stack_memory_if: MEM-stage request/response bundle between the datapath and the data/stack memory.
interface data_stack_memory_if import data_stack_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [DATA_W-1:0] DataIn, DataOut;
  logic [ADDR_W-1:0] Addr, StackPointer;
  logic WriteMem, ReadMem, useStk, Push, Pop, ClearFault;
  logic DataValid, StkEmpty, StkFull, Fault;
  logic [1:0] FaultCode;
  modport master(
    output DataIn, Addr, WriteMem, ReadMem, useStk, Push, Pop, ClearFault,
    input DataOut, DataValid, StackPointer, StkEmpty, StkFull, Fault, FaultCode
  );
  modport slave(
    input DataIn, Addr, WriteMem, ReadMem, useStk, Push, Pop, ClearFault,
    output DataOut, DataValid, StackPointer, StkEmpty, StkFull, Fault, FaultCode
  );
endinterface

// File: rtl/sync_ram_sp.sv
// sync_ram_sp: single-port RAM with write enable and registered, read-before-write output.
module sync_ram_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH = 300
) (
  input  logic              Clock,
  input  logic              We,
  input  logic              Re,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Q
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge Clock) begin
    if (We) mem[Addr] <= Din;
    if (Re) Q <= mem[Addr];
  end
endmodule

// File: rtl/data_stack_memory.sv
// data_stack_memory: general RAM bank plus hardware stack with pointer, indexed frame access and sticky faults.
module data_stack_memory import data_stack_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input logic Clock,
  input logic Reset,
  data_stack_memory_if.slave bus
);
  if (STK_DEPTH >= 2**ADDR_W || RAM_DEPTH > 2**ADDR_W) begin : gBadDepth
    $error("data_stack_memory: depth does not fit ADDR_W");
  end
  logic [ADDR_W-1:0] sp, spNext, stkAddr;
  logic [DATA_W-1:0] ramQ, stkQ, hold, dataOut;
  logic ramWe, ramRe, stkWe, stkRe, rdIssue, rdValid;
  logic stkEmpty, stkFull, outOfRange, faultReg;
  fault_t fcode, codeReg;
  rd_src_t rdSrc, rdSel;
  assign stkEmpty = sp == '0;
  assign stkFull = int'(sp) == STK_DEPTH;
  assign outOfRange = int'(bus.Addr) >= (bus.useStk ? STK_DEPTH : RAM_DEPTH);
  // Stack ops pre-empt indexed ops; Push+Pop on a non-empty stack replaces the top in place.
  always_comb begin
    ramWe = 1'b0;
    ramRe = 1'b0;
    stkWe = 1'b0;
    stkRe = 1'b0;
    stkAddr = sp;
    spNext = sp;
    fcode = FAULT_NONE;
    rdIssue = 1'b0;
    rdSrc = SRC_ZERO;
    if (bus.Push && bus.Pop && !stkEmpty) begin
      stkAddr = sp - ADDR_W'(1);
      stkWe = 1'b1;
      stkRe = 1'b1;
      rdIssue = 1'b1;
      rdSrc = SRC_STK;
    end else if (bus.Push) begin
      if (stkFull) fcode = FAULT_OVF;
      else begin
        stkWe = 1'b1;
        spNext = sp + ADDR_W'(1);
      end
    end else if (bus.Pop) begin
      if (stkEmpty) fcode = FAULT_UNF;
      else begin
        stkAddr = sp - ADDR_W'(1);
        stkRe = 1'b1;
        spNext = sp - ADDR_W'(1);
        rdIssue = 1'b1;
        rdSrc = SRC_STK;
      end
    end else if (bus.WriteMem || bus.ReadMem) begin
      rdIssue = bus.ReadMem;
      if (outOfRange) fcode = FAULT_RANGE;
      else if (bus.useStk) begin
        stkAddr = bus.Addr;
        stkWe = bus.WriteMem;
        stkRe = bus.ReadMem;
        rdSrc = SRC_STK;
      end else begin
        ramWe = bus.WriteMem;
        ramRe = bus.ReadMem;
        rdSrc = SRC_RAM;
      end
    end
  end
  sync_ram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(RAM_DEPTH)) uRam (
    .Clock(Clock), .We(ramWe), .Re(ramRe), .Addr(bus.Addr), .Din(bus.DataIn), .Q(ramQ)
  );
  sync_ram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(STK_DEPTH)) uStk (
    .Clock(Clock), .We(stkWe), .Re(stkRe), .Addr(stkAddr), .Din(bus.DataIn), .Q(stkQ)
  );
  // Bank outputs only change on a read, but the mux can switch banks, so the last result is held separately.
  assign dataOut = !rdValid ? hold : rdSel == SRC_RAM ? ramQ : rdSel == SRC_STK ? stkQ : '0;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sp <= '0;
      rdValid <= 1'b0;
      rdSel <= SRC_ZERO;
      hold <= '0;
      faultReg <= 1'b0;
      codeReg <= FAULT_NONE;
    end else begin
      sp <= spNext;
      rdValid <= rdIssue;
      rdSel <= rdSrc;
      hold <= dataOut;
      if (fcode != FAULT_NONE && (!faultReg || bus.ClearFault)) begin
        faultReg <= 1'b1;
        codeReg <= fcode;
      end else if (bus.ClearFault) begin
        faultReg <= 1'b0;
        codeReg <= FAULT_NONE;
      end
    end
  end
  assign bus.DataOut = dataOut;
  assign bus.DataValid = rdValid;
  assign bus.StackPointer = sp;
  assign bus.StkEmpty = stkEmpty;
  assign bus.StkFull = stkFull;
  assign bus.Fault = faultReg;
  assign bus.FaultCode = codeReg;
endmodule
